// File: rtl/tlb_unit.sv
// Fully-associative dual-port joint TLB with registered one-cycle lookup, TLBWI/TLBWR/TLBP/TLBR
// and a hardware Random register. Define TLB_INST_MAP_EN to translate the instruction port.
module tlb_unit #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PA_W    = 32,
  localparam int unsigned IDX_W  = $clog2(ENTRIES),
  localparam int unsigned PFN_W  = PA_W - 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [31:0]       i_va_i,
  input  logic              d_req_i,
  input  logic [31:0]       d_va_i,
  input  logic              d_store_i,
  output logic              i_valid_o,
  output logic [PA_W-1:0]   i_pa_o,
  output logic              i_refill_o,
  output logic              i_invalid_o,
  output logic [2:0]        i_cache_o,
  output logic              d_valid_o,
  output logic [PA_W-1:0]   d_pa_o,
  output logic              d_refill_o,
  output logic              d_invalid_o,
  output logic              d_mod_o,
  output logic [2:0]        d_cache_o,
  input  logic [31:0]       entryhi_i,
  input  logic [31:0]       entrylo0_i,
  input  logic [31:0]       entrylo1_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [IDX_W-1:0]  wired_i,
  input  logic              wired_we_i,
  input  logic              tlbwi,
  input  logic              tlbwr,
  input  logic              tlbp,
  input  logic              tlbr,
  output logic [IDX_W-1:0]  random_o,
  output logic              op_done_o,
  output logic [31:0]       probe_o,
  output logic [31:0]       entryhi_o,
  output logic [31:0]       entrylo0_o,
  output logic [31:0]       entrylo1_o
);

  localparam logic [IDX_W-1:0] RandMax = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic [PA_W-1:0] pa;
    logic [2:0]      cache;
    logic            refill;
    logic            invalid;
    logic            modf;
  } res_t;

  logic [18:0]      vpn2_q   [ENTRIES];
  logic [7:0]       asid_q   [ENTRIES];
  logic             global_q [ENTRIES];
  logic [PFN_W-1:0] pfn0_q   [ENTRIES];
  logic [PFN_W-1:0] pfn1_q   [ENTRIES];
  logic [2:0]       c0_q     [ENTRIES];
  logic [2:0]       c1_q     [ENTRIES];
  logic             d0_q     [ENTRIES];
  logic             d1_q     [ENTRIES];
  logic             v0_q     [ENTRIES];
  logic             v1_q     [ENTRIES];
  logic             used_q   [ENTRIES];

  logic [IDX_W-1:0] random_q, random_d;
  logic             wr_en, do_probe, do_read;
  logic [IDX_W-1:0] wr_idx;

  logic [ENTRIES-1:0] d_match, p_match;
  logic [IDX_W-1:0]   d_idx, p_idx;
  res_t               d_res, i_res, d_res_q, i_res_q;
  logic               d_valid_q, i_valid_q;

  logic        op_done_q;
  logic [31:0] probe_d, probe_q;
  logic [31:0] rd_hi, rd_lo0, rd_lo1, entryhi_q, entrylo0_q, entrylo1_q;
  logic        unused_cp0;

  // Lowest matching index wins.
  function automatic logic [IDX_W-1:0] first_idx(input logic [ENTRIES-1:0] m);
    first_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (m[i]) first_idx = IDX_W'(i);
    end
  endfunction

  function automatic res_t translate(input logic [31:0] va, input logic store, input logic hit,
                                     input logic [PFN_W-1:0] pfn, input logic [2:0] c,
                                     input logic dirty, input logic valid);
    res_t        r;
    logic [31:0] ua;
    r  = '0;
    ua = {3'b000, va[28:0]};
    if (va[31:30] == 2'b10) begin
      r.pa    = ua[PA_W-1:0];
      r.cache = 3'd2;
    end else if (!hit) begin
      r.refill = 1'b1;
    end else if (!valid) begin
      r.invalid = 1'b1;
    end else if (store && !dirty) begin
      r.modf = 1'b1;
    end else begin
      r.pa    = {pfn, va[11:0]};
      r.cache = c;
    end
    return r;
  endfunction

  // Strobe decode: only the highest-priority operation executes.
  assign wr_en    = tlbwi | tlbwr;
  assign wr_idx   = tlbwi ? index_i : random_q;
  assign do_probe = tlbp & ~wr_en;
  assign do_read  = tlbr & ~wr_en & ~tlbp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vpn2_q[i]   <= '0;
        asid_q[i]   <= '0;
        global_q[i] <= 1'b0;
        pfn0_q[i]   <= '0;
        pfn1_q[i]   <= '0;
        c0_q[i]     <= '0;
        c1_q[i]     <= '0;
        d0_q[i]     <= 1'b0;
        d1_q[i]     <= 1'b0;
        v0_q[i]     <= 1'b0;
        v1_q[i]     <= 1'b0;
        used_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      vpn2_q[wr_idx]   <= entryhi_i[31:13];
      asid_q[wr_idx]   <= entryhi_i[7:0];
      global_q[wr_idx] <= entrylo0_i[0] & entrylo1_i[0];
      pfn0_q[wr_idx]   <= entrylo0_i[PFN_W+5:6];
      pfn1_q[wr_idx]   <= entrylo1_i[PFN_W+5:6];
      c0_q[wr_idx]     <= entrylo0_i[5:3];
      c1_q[wr_idx]     <= entrylo1_i[5:3];
      d0_q[wr_idx]     <= entrylo0_i[2];
      d1_q[wr_idx]     <= entrylo1_i[2];
      v0_q[wr_idx]     <= entrylo0_i[1];
      v1_q[wr_idx]     <= entrylo1_i[1];
      used_q[wr_idx]   <= 1'b1;
    end
  end

  always_comb begin
    if (wired_we_i || random_q <= wired_i) random_d = RandMax;
    else                                   random_d = random_q - IDX_W'(1);
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_match
    assign d_match[e] = used_q[e] && (vpn2_q[e] == d_va_i[31:13]) &&
                        (global_q[e] || asid_q[e] == entryhi_i[7:0]);
    assign p_match[e] = used_q[e] && (vpn2_q[e] == entryhi_i[31:13]) &&
                        (global_q[e] || asid_q[e] == entryhi_i[7:0]);
  end

  assign d_idx = first_idx(d_match);
  assign p_idx = first_idx(p_match);

  always_comb begin
    d_res = translate(d_va_i, d_store_i, |d_match,
                      d_va_i[12] ? pfn1_q[d_idx] : pfn0_q[d_idx],
                      d_va_i[12] ? c1_q[d_idx]   : c0_q[d_idx],
                      d_va_i[12] ? d1_q[d_idx]   : d0_q[d_idx],
                      d_va_i[12] ? v1_q[d_idx]   : v0_q[d_idx]);
  end

`ifdef TLB_INST_MAP_EN
  logic [ENTRIES-1:0] i_match;
  logic [IDX_W-1:0]   i_idx;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_imatch
    assign i_match[e] = used_q[e] && (vpn2_q[e] == i_va_i[31:13]) &&
                        (global_q[e] || asid_q[e] == entryhi_i[7:0]);
  end

  assign i_idx = first_idx(i_match);

  always_comb begin
    i_res = translate(i_va_i, 1'b0, |i_match,
                      i_va_i[12] ? pfn1_q[i_idx] : pfn0_q[i_idx],
                      i_va_i[12] ? c1_q[i_idx]   : c0_q[i_idx],
                      i_va_i[12] ? d1_q[i_idx]   : d0_q[i_idx],
                      i_va_i[12] ? v1_q[i_idx]   : v0_q[i_idx]);
  end
`else
  logic [31:0] i_ua;
  logic        unused_i_va;

  always_comb begin
    i_res       = '0;
    i_ua        = {3'b000, i_va_i[28:0]};
    i_res.pa    = i_ua[PA_W-1:0];
    i_res.cache = 3'd2;
  end

  assign unused_i_va = ^i_va_i[31:29];
`endif

  always_comb begin
    probe_d            = '0;
    probe_d[31]        = ~|p_match;
    probe_d[IDX_W-1:0] = p_idx;
  end

  assign rd_hi  = {vpn2_q[index_i], 5'b00000, asid_q[index_i]};
  assign rd_lo0 = 32'({pfn0_q[index_i], c0_q[index_i], d0_q[index_i], v0_q[index_i],
                       global_q[index_i]});
  assign rd_lo1 = 32'({pfn1_q[index_i], c1_q[index_i], d1_q[index_i], v1_q[index_i],
                       global_q[index_i]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_q   <= RandMax;
      d_valid_q  <= 1'b0;
      i_valid_q  <= 1'b0;
      d_res_q    <= '0;
      i_res_q    <= '0;
      op_done_q  <= 1'b0;
      probe_q    <= '0;
      entryhi_q  <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
    end else begin
      random_q  <= random_d;
      d_valid_q <= d_req_i;
      i_valid_q <= i_req_i;
      op_done_q <= do_probe | do_read;
      if (d_req_i)  d_res_q <= d_res;
      if (i_req_i)  i_res_q <= i_res;
      if (do_probe) probe_q <= probe_d;
      if (do_read) begin
        entryhi_q  <= rd_hi;
        entrylo0_q <= rd_lo0;
        entrylo1_q <= rd_lo1;
      end
    end
  end

  assign unused_cp0 = ^{entryhi_i[12:8], entrylo0_i[31:PFN_W+6], entrylo1_i[31:PFN_W+6]};

  assign d_valid_o   = d_valid_q;
  assign d_pa_o      = d_res_q.pa;
  assign d_cache_o   = d_res_q.cache;
  assign d_refill_o  = d_res_q.refill;
  assign d_invalid_o = d_res_q.invalid;
  assign d_mod_o     = d_res_q.modf;
  assign i_valid_o   = i_valid_q;
  assign i_pa_o      = i_res_q.pa;
  assign i_cache_o   = i_res_q.cache;
  assign i_refill_o  = i_res_q.refill;
  assign i_invalid_o = i_res_q.invalid;
  assign random_o    = random_q;
  assign op_done_o   = op_done_q;
  assign probe_o     = probe_q;
  assign entryhi_o   = entryhi_q;
  assign entrylo0_o  = entrylo0_q;
  assign entrylo1_o  = entrylo1_q;

endmodule

// File: doc/tlb_unit.md
# tlb_unit

Parametrised, fully-associative, dual-port joint TLB for the MIPS32 core; the successor to the fixed 16-entry combinational translator. It translates instruction-fetch and data-memory virtual addresses through a one-cycle registered lookup pipeline. It raises refill, invalid and modified exceptions, and implements TLBWI/TLBWR/TLBP/TLBR together with a hardware Random register. It sits between the MEM/IF stages and the SRAM controller; CP0 supplies EntryHi/EntryLo/Index/Wired.

## Interface
- ENTRIES, 16, number of TLB entries; power of two, 4..64. IDX_W = $clog2(ENTRIES).
- PA_W, 32, physical address width; PFN_W = PA_W-12.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req_i / d_req_i  in  1  lookup request, instruction / data port.
- i_va_i / d_va_i  in  32  virtual address.
- d_store_i  in  1  data request is a store.
- i_valid_o / d_valid_o  out  1  result valid, one cycle after request.
- i_pa_o / d_pa_o  out  PA_W  physical address.
- i_refill_o / d_refill_o  out  1  no matching entry.
- i_invalid_o / d_invalid_o  out  1  match, but the selected page has V=0.
- d_mod_o  out  1  store to a page with D=0.
- i_cache_o / d_cache_o  out  3  C field of the selected page; 3'd2 when unmapped.
- entryhi_i, entrylo0_i, entrylo1_i  in  32  CP0 source for writes; entryhi_i[7:0] is the current ASID for lookups.
- index_i  in  IDX_W  TLBWI target.
- wired_i  in  IDX_W  Wired register.
- wired_we_i  in  1  CP0 is writing Wired this cycle.
- tlbwi, tlbwr, tlbp, tlbr  in  1  single-cycle operation strobes.
- random_o  out  IDX_W  Random register.
- op_done_o  out  1  TLBP/TLBR result valid, one cycle after the strobe.
- probe_o  out  32  bit31 = P (1 = no match), [IDX_W-1:0] = matching index, all other bits 0.
- entryhi_o, entrylo0_o, entrylo1_o  out  32  TLBR result in CP0 field layout; G is replicated into bit0 of both EntryLo words.

## Operation
- Entry contents: VPN2[18:0], ASID[7:0], G, PFN0/PFN1, C0/C1, D0/D1, V0/V1, plus an internal `used` bit.
- Writes store G = entrylo0_i[0] & entrylo1_i[0] and set `used`. Reset clears `used` in every entry; an unused entry never matches.
- Segment decode:
  - va[31:30]==2'b10 (kseg0/kseg1) is unmapped: pa = {3'b000, va[28:0]} truncated to PA_W. No exceptions raised.
  - All other segments are mapped.
- Match rule: `used` && VPN2 == va[31:13] && (G || ASID == entryhi_i[7:0]). When several entries match, the lowest index wins.
- Page select: va[12]=0 selects PFN0/C0/D0/V0; va[12]=1 selects PFN1/C1/D1/V1. pa = {PFN, va[11:0]}.
- Exception priority per port: refill > invalid > modified.
  - On any exception: pa = 0, cache = 0.
  - d_mod_o only when d_store_i=1 and V=1 and D=0.
- Write index: TLBWI uses index_i; TLBWR uses random_o.
- TLBP compares entryhi_i VPN2/ASID against all entries using the same match rule.
- TLBR reads entry index_i.
- Strobe priority when several are asserted in one cycle: tlbwi > tlbwr > tlbp > tlbr. Only the highest is executed.
- Random register:
  - Reset value ENTRIES-1.
  - Each cycle: if wired_we_i, next = ENTRIES-1; else if random_o <= wired_i, next = ENTRIES-1; else next = random_o-1.
  - Never below wired_i. When wired_i >= ENTRIES-1, random_o holds at ENTRIES-1.

## Timing
- Lookup latency: one cycle. All lookup outputs are registered; *_valid_o = *_req_i delayed one cycle.
- Outputs hold their last values until the next request.
- Both ports are independent and may request every cycle (full throughput).
- A lookup in the same cycle as a write sees the old contents. A lookup issued the cycle after a write sees the new entry.
- TLBP/TLBR: op_done_o pulses one cycle after the strobe. Results on probe_o / entry*_o hold until the next TLBP/TLBR.
- Reset values (asynchronous): all *_valid_o, exception outputs, *_pa_o, *_cache_o, op_done_o, probe_o and entry*_o are 0; random_o = ENTRIES-1.
- Reset asserted mid-lookup: the pending result is discarded, and no valid pulse follows reset release.

## Configuration
- TLB_INST_MAP_EN:
  - Defined: the instruction port is translated exactly like the data port, and i_refill_o / i_invalid_o are live.
  - Undefined: every instruction address is treated as unmapped (pa = {3'b000, va[28:0]}), i_refill_o / i_invalid_o are tied 0, and the second match array is not built.

## Test plan
- Write hit, even page: after reset, TLBWI index 3 with EntryHi 0x00402005 (VPN2 0x00201, ASID 5), EntryLo0 PFN 0x123 V=1 D=1, EntryLo1 V=1 D=0. Then d_req at va 0x00402A10, load, ASID 5 -> next cycle d_valid_o=1, d_pa_o=0x00123A10, no exceptions.
- Exception cases on that entry:
  - Store to va 0x00403010 (odd page, D=0) -> d_mod_o=1, d_pa_o=0.
  - Same va with ASID 6 -> d_refill_o=1.
  - Entry rewritten with V0=0, load 0x00402000 -> d_invalid_o=1.
- Unmapped bypass: d_req at va 0xA0001234 with an empty TLB -> d_pa_o=0x00001234, d_cache_o=2, no exceptions.
- Random register: ENTRIES=16, wired_i=4 -> random_o walks 15,14,...,4,15. Pulse wired_we_i mid-walk -> next cycle random_o=15. TLBWR lands in the entry named by random_o in that cycle.
- TLBP/TLBR: probe for the existing entry -> op_done_o next cycle, probe_o=0x00000003. Probe for an absent VPN2 -> probe_o=0x80000000. TLBR index 3 -> entryhi_o=0x00402005 and EntryLo fields reproduced.
- Same-cycle collisions:
  - TLBWI and a d_req on the written VPN in the same cycle -> refill. The repeat request next cycle -> hit.
  - Two matching entries at indices 2 and 7 -> index 2's PFN is used.
  - Asynchronous rst during a request -> d_valid_o=0 and random_o=ENTRIES-1.
